// File: rtl/roulette_spin_driver.sv
`default_nettype none
// ============================================================================
// Module      : roulette_spin_driver
// Description : Autonomous roulette spin animation with multiplexed LED group
//               decode. Optional HOLD blink enabled by ROULETTE_BLINK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module roulette_spin_driver #(
    parameter int NUM_LEDS    = 38,
    parameter int GROUPS      = 6,
    parameter int SEL_W       = 3,
    parameter int IDX_W       = 6,
    parameter int PERIOD_INIT = 4,
    parameter int PERIOD_INC  = 2,
    parameter int PERIOD_W    = 16,
    parameter int MIN_LAPS    = 1
`ifdef ROULETTE_BLINK_EN
    ,
    parameter int BLINK_LOG2  = 4
`endif
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [IDX_W-1:0]          target,
    output logic [GROUPS*SEL_W-1:0]   mux_sel,
    output logic [IDX_W-1:0]          led_number,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int                c_lpg    = (2 ** SEL_W) - 1;
    localparam int                c_laps_w = 8;
    localparam logic [IDX_W-1:0]  c_last   = IDX_W'(NUM_LEDS - 1);

    if (GROUPS * c_lpg < NUM_LEDS) begin : g_param_check
        $error("roulette_spin_driver: GROUPS*(2^SEL_W-1) must cover NUM_LEDS");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SPIN   = 2'd1,
        S_SETTLE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t                    r_state,  w_state_nxt;
    logic [IDX_W-1:0]          r_pos,    w_pos_nxt;
    logic [IDX_W-1:0]          r_target, w_target_nxt;
    logic [PERIOD_W-1:0]       r_cnt,    w_cnt_nxt;
    logic [PERIOD_W-1:0]       r_period, w_period_nxt;
    logic [c_laps_w-1:0]       r_laps,   w_laps_nxt;
    logic [GROUPS*SEL_W-1:0]   r_mux,    w_mux_nxt;
    logic                      r_done,   w_done_nxt;
    logic                      r_err,    w_err_nxt;
    logic                      w_start_ok, w_step, w_wrap;
    logic [IDX_W-1:0]          w_pos_inc;
    logic [PERIOD_W:0]         w_psum;

`ifdef ROULETTE_BLINK_EN
    logic [BLINK_LOG2-1:0]     r_blink, w_blink_nxt;
`endif

    // Pocket i lights group i/LPG with code (i%LPG)+1; other groups dark.
    function automatic logic [GROUPS*SEL_W-1:0] f_decode(input logic [IDX_W-1:0] idx);
        logic [GROUPS*SEL_W-1:0] v;
        int                      grp;
        int                      code;
        v    = '0;
        grp  = 32'(idx) / c_lpg;
        code = (32'(idx) % c_lpg) + 1;
        for (int g = 0; g < GROUPS; g++) begin
            if (grp == g) v[g*SEL_W +: SEL_W] = SEL_W'(code);
        end
        return v;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_pos    <= '0;
            r_target <= '0;
            r_cnt    <= '0;
            r_period <= PERIOD_W'(PERIOD_INIT);
            r_laps   <= '0;
            r_mux    <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pos    <= w_pos_nxt;
            r_target <= w_target_nxt;
            r_cnt    <= w_cnt_nxt;
            r_period <= w_period_nxt;
            r_laps   <= w_laps_nxt;
            r_mux    <= w_mux_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

`ifdef ROULETTE_BLINK_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_blink <= '0;
        else        r_blink <= w_blink_nxt;
    end
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_pos_nxt    = r_pos;
        w_target_nxt = r_target;
        w_cnt_nxt    = r_cnt;
        w_period_nxt = r_period;
        w_laps_nxt   = r_laps;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_start_ok   = start && (32'(target) < NUM_LEDS);
        w_step       = (r_cnt == r_period - PERIOD_W'(1));
        w_wrap       = w_step && (r_pos == c_last);
        w_pos_inc    = w_wrap ? '0 : r_pos + IDX_W'(1);
        w_psum       = {1'b0, r_period} + (PERIOD_W+1)'(PERIOD_INC);

        case (r_state)
            S_IDLE, S_HOLD: begin
                if (w_start_ok) begin
                    w_state_nxt  = S_SPIN;
                    w_pos_nxt    = '0;
                    w_cnt_nxt    = '0;
                    w_laps_nxt   = '0;
                    w_period_nxt = PERIOD_W'(PERIOD_INIT);
                    w_target_nxt = target;
                end else if (start) begin
                    w_err_nxt = 1'b1;
                end
            end
            default: begin
                if (w_step) begin
                    w_cnt_nxt = '0;
                    w_pos_nxt = w_pos_inc;
                    if (w_wrap) begin
                        w_laps_nxt   = (r_laps == '1) ? r_laps : r_laps + c_laps_w'(1);
                        w_period_nxt = w_psum[PERIOD_W] ? '1 : w_psum[PERIOD_W-1:0];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + PERIOD_W'(1);
                end
                // SPIN only decides at a lap wrap; SETTLE lands on any matching step.
                if (r_state == S_SPIN) begin
                    if (w_wrap && (32'(w_laps_nxt) >= MIN_LAPS)) begin
                        if (w_pos_inc == r_target) begin
                            w_state_nxt = S_HOLD;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_SETTLE;
                        end
                    end
                end else if (w_step && (w_pos_inc == r_target)) begin
                    w_state_nxt = S_HOLD;
                    w_done_nxt  = 1'b1;
                end
            end
        endcase

`ifdef ROULETTE_BLINK_EN
        w_blink_nxt = ((w_state_nxt == S_HOLD) && (r_state != S_HOLD)) ? '0 : r_blink + BLINK_LOG2'(1);
`endif

        // Decode follows the next pos so mux_sel and led_number update together.
        case (w_state_nxt)
            S_IDLE: w_mux_nxt = '0;
            S_HOLD: begin
                w_mux_nxt = f_decode(w_target_nxt);
`ifdef ROULETTE_BLINK_EN
                if (w_blink_nxt[BLINK_LOG2-1]) w_mux_nxt = '0;
`endif
            end
            default: w_mux_nxt = f_decode(w_pos_nxt);
        endcase
    end

    assign mux_sel    = r_mux;
    assign led_number = r_pos;
    assign busy       = (r_state == S_SPIN) || (r_state == S_SETTLE);
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_roulette_spin_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_roulette_spin_driver
// Description : Scoreboard bench for roulette_spin_driver (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_roulette_spin_driver;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  target = '0;
    logic [17:0] mux_sel;
    logic [5:0]  led_number;
    logic        busy, done, err;

    roulette_spin_driver dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .target     (target),
        .mux_sel    (mux_sel),
        .led_number (led_number),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          is_err;
        int          due;
        logic [17:0] mux;
        logic [5:0]  led;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: every done/err pulse must match the oldest expected event.
    always @(negedge clock) begin
        if (reset && (done || err)) begin
            if (q.size() == 0) begin
                chk("unexpected_event", {30'd0, done, err}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk(e.is_err ? "err_pulse" : "done_pulse", {31'd0, e.is_err ? err : done}, 32'd1);
                chk("event_cycle", cyc, e.due);
                if (!e.is_err) begin
                    chk("hold_mux_sel", 32'(mux_sel), 32'(e.mux));
                    chk("hold_led_number", 32'(led_number), 32'(e.led));
                    chk("hold_busy", 32'(busy), 32'd0);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Issue start for one cycle; returns the cycle index at which SPIN begins.
    task automatic issue(input logic [5:0] tgt, output int entry);
        start  = 1'b1;
        target = tgt;
        entry  = cyc + 1;
        tick(1);
        start  = 1'b0;
    endtask

    task automatic drain(input string name);
        int i;
        for (i = 0; i < 600 && q.size() != 0; i++) tick(1);
        chk(name, q.size(), 0);
        q.delete();
    endtask

    initial begin
        int e;
        // Reset state
        #2;
        chk("rst_mux_sel", 32'(mux_sel), 0);
        chk("rst_led", 32'(led_number), 0);
        chk("rst_busy_done_err", {29'd0, busy, done, err}, 0);
        tick(2);
        reset = 1'b1;
        tick(2);
        chk("idle_busy", 32'(busy), 0);

        // target 5: lap of 152 cycles at period 4, then 30 cycles at period 6
        issue(6'd5, e);
        q.push_back('{is_err: 1'b0, due: e + 182, mux: 18'd6, led: 6'd5});
        chk("spin_entry_busy", 32'(busy), 1);
        chk("spin_entry_led", 32'(led_number), 0);
        chk("spin_entry_mux", 32'(mux_sel), 1);
        tick(151);
        chk("pos37_led", 32'(led_number), 37);
        chk("pos37_mux", 32'(mux_sel), 32'd3 << 15);
        tick(1);
        chk("wrap_led", 32'(led_number), 0);
        chk("wrap_busy", 32'(busy), 1);
        tick(5);
        chk("period6_hold_pos0", 32'(led_number), 0);
        tick(1);
        chk("period6_pos1", 32'(led_number), 1);
        drain("done_t5_timeout");
        tick(5);
        chk("hold_steady_mux", 32'(mux_sel), 6);

        // target 0 lands right at the first-lap wrap
        issue(6'd0, e);
        q.push_back('{is_err: 1'b0, due: e + 152, mux: 18'd1, led: 6'd0});
        drain("done_t0_timeout");

        // target 9: group 1 code 3; stray start at cycle 20 must be ignored
        issue(6'd9, e);
        q.push_back('{is_err: 1'b0, due: e + 152 + 54, mux: 18'd3 << 3, led: 6'd9});
        tick(19);
        start = 1'b1; target = 6'd12;
        tick(1);
        start = 1'b0;
        drain("done_t9_timeout");

        // invalid start in HOLD pulses err and holds the display
        start = 1'b1; target = 6'd40;
        q.push_back('{is_err: 1'b1, due: cyc + 1, mux: '0, led: '0});
        tick(1);
        start = 1'b0;
        drain("err_hold_timeout");
        tick(1);
        chk("hold_after_err_led", 32'(led_number), 9);
        chk("hold_after_err_mux", 32'(mux_sel), 32'd3 << 3);

        // restart from HOLD to the last pocket: group 5 code 3
        issue(6'd37, e);
        q.push_back('{is_err: 1'b0, due: e + 152 + 222, mux: 18'd3 << 15, led: 6'd37});
        drain("done_t37_timeout");

        // reset mid-spin, then invalid start from IDLE
        issue(6'd5, e);
        tick(49);
        reset = 1'b0;
        #1;
        chk("async_rst_mux", 32'(mux_sel), 0);
        chk("async_rst_led", 32'(led_number), 0);
        chk("async_rst_busy", 32'(busy), 0);
        tick(2);
        reset = 1'b1;
        tick(3);
        chk("post_rst_idle_busy", 32'(busy), 0);
        chk("post_rst_idle_mux", 32'(mux_sel), 0);
        start = 1'b1; target = 6'd40;
        q.push_back('{is_err: 1'b1, due: cyc + 1, mux: '0, led: '0});
        tick(1);
        start = 1'b0;
        drain("err_idle_timeout");
        tick(2);
        chk("err_idle_busy", 32'(busy), 0);
        chk("err_idle_mux", 32'(mux_sel), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
